// File: rtl/mul_div_unit_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg : shared definitions for the HI/LO multiply/divide unit.
//   - mdu_op_e    : 3-bit execute-stage opcode presented to the unit
//   - mdu_state_e : divide sequencer states
//   - DIV_ITERS   : restoring-divide iteration count (one quotient bit/cycle)
//   - helpers     : opcode classification used by the datapath and stall logic
// ---------------------------------------------------------------------------
package mdu_pkg;

   typedef enum logic [2:0] {
      MDU_NONE  = 3'd0,
      MDU_MULT  = 3'd1,
      MDU_MULTU = 3'd2,
      MDU_DIV   = 3'd3,
      MDU_DIVU  = 3'd4,
      MDU_MTHI  = 3'd5,
      MDU_MTLO  = 3'd6,
      MDU_RSVD  = 3'd7
   } mdu_op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DIV  = 2'd1,
      S_DONE = 2'd2
   } mdu_state_e;

   localparam int DIV_ITERS = 32;
   localparam int CNT_W     = $clog2(DIV_ITERS);

   // True for the two opcodes that start the iterative divider.
   function automatic logic is_div_op(input logic [2:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// ---------------------------------------------------------------------------
// mul_div_unit_if : execute-stage <-> multiply/divide unit bundle.
//   master (pipeline side) drives : flush, in_valid, op, src_a, src_b,
//                                   hi_in, lo_in
//   slave  (mul_div_unit)  drives : stall, hilo_wen, hilo_wdata
// ---------------------------------------------------------------------------
interface mul_div_unit_if #(
   parameter int WIDTH = 32
) ();

   logic                 flush;
   logic                 in_valid;
   logic [2:0]           op;
   logic [WIDTH-1:0]     src_a;
   logic [WIDTH-1:0]     src_b;
   logic [WIDTH-1:0]     hi_in;
   logic [WIDTH-1:0]     lo_in;
   logic                 stall;
   logic                 hilo_wen;
   logic [2*WIDTH-1:0]   hilo_wdata;

   modport master (
      output flush, in_valid, op, src_a, src_b, hi_in, lo_in,
      input  stall, hilo_wen, hilo_wdata
   );

   modport slave (
      input  flush, in_valid, op, src_a, src_b, hi_in, lo_in,
      output stall, hilo_wen, hilo_wdata
   );

endinterface

// File: rtl/mul_div_unit_div_iter.sv
// ---------------------------------------------------------------------------
// div_iter : one combinational radix-2 restoring division step.
//   rem_in       : current partial remainder (always < divisor)
//   dividend_bit : next dividend bit shifted into the remainder
//   divisor      : unsigned divisor magnitude
//   rem_out      : partial remainder after the step
//   quo_bit      : quotient bit produced by the step
// ---------------------------------------------------------------------------
module div_iter #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             dividend_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             quo_bit
);

   logic [WIDTH:0] shifted_s;
   logic [WIDTH:0] diff_s;

   // Trial subtraction one bit wider than the operands; the top bit of the
   // difference is the borrow, which means "restore the shifted remainder".
   always_comb begin
      shifted_s = {rem_in, dividend_bit};
      diff_s    = shifted_s - {1'b0, divisor};
      if (diff_s[WIDTH] == 1'b0) begin
         rem_out = diff_s[WIDTH-1:0];
         quo_bit = 1'b1;
      end else begin
         rem_out = {rem_in[WIDTH-2:0], dividend_bit};
         quo_bit = 1'b0;
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit : execute-stage HI/LO producer (MULT, MULTU, DIV, DIVU,
//                MTHI, MTLO) feeding the HI/LO register file.
//   clk   : core clock, rising edge
//   reset : asynchronous, active-low
//   bus   : mul_div_unit_if.slave
//           in  flush, in_valid, op, src_a, src_b, hi_in, lo_in
//           out stall (combinational), hilo_wen, hilo_wdata ({HI, LO})
// Multiplies and moves write one cycle after accept. Divides run a
// 32-step restoring sequence and stall the pipeline until the write cycle.
// ---------------------------------------------------------------------------
module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH         = 32,
   parameter bit DIV_ZERO_FAST = 1'b1
) (
   input  logic           clk,
   input  logic           reset,
   mul_div_unit_if.slave  bus
);

   mdu_state_e           state_r, state_next_s;
   logic [CNT_W-1:0]     cnt_r, cnt_next_s;
   logic [WIDTH-1:0]     rem_r, rem_next_s;
   logic [WIDTH-1:0]     quo_r, quo_next_s;     // dividend shifts out, quotient shifts in
   logic [WIDTH-1:0]     dvsr_r, dvsr_next_s;
   logic                 q_neg_r, q_neg_next_s;
   logic                 r_neg_r, r_neg_next_s;
   logic                 div0_r, div0_next_s;
   logic                 wen_r, wen_next_s;
   logic [2*WIDTH-1:0]   wdata_r, wdata_next_s;

   logic                 accept_s;
   logic                 div_signed_s;
   logic                 a_neg_s, b_neg_s;
   logic [WIDTH-1:0]     a_abs_s, b_abs_s;
   logic [2*WIDTH-1:0]   prod_s, uprod_s;
   logic [WIDTH-1:0]     iter_rem_s;
   logic                 iter_qbit_s;
   logic [WIDTH-1:0]     quo_raw_s, quo_fin_s, rem_fin_s;

   // Two's-complement negate.
   function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
      return ~x + WIDTH'(1);
   endfunction

   div_iter #(.WIDTH(WIDTH)) u_div_iter (
      .rem_in       (rem_r),
      .dividend_bit (quo_r[WIDTH-1]),
      .divisor      (dvsr_r),
      .rem_out      (iter_rem_s),
      .quo_bit      (iter_qbit_s)
   );

   assign accept_s = (state_r == S_IDLE) && bus.in_valid && !bus.flush;

   // Operand conditioning, products and divide sign fixup.
   always_comb begin
      div_signed_s = (bus.op == MDU_DIV);
      a_neg_s      = div_signed_s & bus.src_a[WIDTH-1];
      b_neg_s      = div_signed_s & bus.src_b[WIDTH-1];
      a_abs_s      = a_neg_s ? neg(bus.src_a) : bus.src_a;
      b_abs_s      = b_neg_s ? neg(bus.src_b) : bus.src_b;
      // Low 2*WIDTH bits of a product of sign-extended operands equal the
      // signed product.
      prod_s  = {{WIDTH{bus.src_a[WIDTH-1]}}, bus.src_a} *
                {{WIDTH{bus.src_b[WIDTH-1]}}, bus.src_b};
      uprod_s = {{WIDTH{1'b0}}, bus.src_a} * {{WIDTH{1'b0}}, bus.src_b};
      quo_raw_s = {quo_r[WIDTH-2:0], iter_qbit_s};
      if (div0_r) begin
         quo_fin_s = {WIDTH{1'b1}};
      end else if (q_neg_r) begin
         quo_fin_s = neg(quo_raw_s);
      end else begin
         quo_fin_s = quo_raw_s;
      end
      // With a zero divisor the remainder ends up equal to |dividend|, so
      // this also restores src_a as the HI result on the slow path.
      rem_fin_s = r_neg_r ? neg(iter_rem_s) : iter_rem_s;
   end

   // Next-state and datapath next values for the sequencer.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      rem_next_s   = rem_r;
      quo_next_s   = quo_r;
      dvsr_next_s  = dvsr_r;
      q_neg_next_s = q_neg_r;
      r_neg_next_s = r_neg_r;
      div0_next_s  = div0_r;
      wen_next_s   = 1'b0;
      wdata_next_s = wdata_r;
      case (state_r)
         S_IDLE: begin
            if (accept_s) begin
               case (bus.op)
                  MDU_MULT: begin
                     wen_next_s   = 1'b1;
                     wdata_next_s = prod_s;
                  end
                  MDU_MULTU: begin
                     wen_next_s   = 1'b1;
                     wdata_next_s = uprod_s;
                  end
                  MDU_MTHI: begin
                     wen_next_s   = 1'b1;
                     wdata_next_s = {bus.src_a, bus.lo_in};
                  end
                  MDU_MTLO: begin
                     wen_next_s   = 1'b1;
                     wdata_next_s = {bus.hi_in, bus.src_a};
                  end
                  MDU_DIV, MDU_DIVU: begin
                     cnt_next_s   = {CNT_W{1'b0}};
                     rem_next_s   = {WIDTH{1'b0}};
                     quo_next_s   = a_abs_s;
                     dvsr_next_s  = b_abs_s;
                     q_neg_next_s = a_neg_s ^ b_neg_s;
                     r_neg_next_s = a_neg_s;
                     div0_next_s  = (bus.src_b == {WIDTH{1'b0}});
                     if ((bus.src_b == {WIDTH{1'b0}}) && DIV_ZERO_FAST) begin
                        state_next_s = S_DONE;
                        wen_next_s   = 1'b1;
                        wdata_next_s = {bus.src_a, {WIDTH{1'b1}}};
                     end else begin
                        state_next_s = S_DIV;
                     end
                  end
                  default: begin
                     state_next_s = S_IDLE;
                  end
               endcase
            end else begin
               state_next_s = S_IDLE;
            end
         end
         S_DIV: begin
            if (bus.flush) begin
               state_next_s = S_IDLE;
            end else begin
               rem_next_s = iter_rem_s;
               quo_next_s = quo_raw_s;
               cnt_next_s = cnt_r + CNT_W'(1);
               if (cnt_r == CNT_W'(DIV_ITERS - 1)) begin
                  state_next_s = S_DONE;
                  wen_next_s   = 1'b1;
                  wdata_next_s = {rem_fin_s, quo_fin_s};
               end else begin
                  state_next_s = S_DIV;
               end
            end
         end
         S_DONE: begin
            state_next_s = S_IDLE;
         end
         default: begin
            state_next_s = S_IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Divide datapath and registered write-port outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_r   <= {CNT_W{1'b0}};
         rem_r   <= {WIDTH{1'b0}};
         quo_r   <= {WIDTH{1'b0}};
         dvsr_r  <= {WIDTH{1'b0}};
         q_neg_r <= 1'b0;
         r_neg_r <= 1'b0;
         div0_r  <= 1'b0;
         wen_r   <= 1'b0;
         wdata_r <= {(2*WIDTH){1'b0}};
      end else begin
         cnt_r   <= cnt_next_s;
         rem_r   <= rem_next_s;
         quo_r   <= quo_next_s;
         dvsr_r  <= dvsr_next_s;
         q_neg_r <= q_neg_next_s;
         r_neg_r <= r_neg_next_s;
         div0_r  <= div0_next_s;
         wen_r   <= wen_next_s;
         wdata_r <= wdata_next_s;
      end
   end

   // A flush in the write cycle (pending MULT-class write or DONE) kills it.
   assign bus.hilo_wen   = wen_r & ~bus.flush;
   assign bus.hilo_wdata = wdata_r;
   // Stall covers the divide accept cycle and every iteration cycle; a flush
   // or an asserted reset drops it immediately.
   assign bus.stall = reset & ~bus.flush &
                      ((state_r == S_DIV) ||
                       ((state_r == S_IDLE) && bus.in_valid && is_div_op(bus.op)));

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Execute-stage HI/LO producer for the MIPS core: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- Sits directly upstream of the HI/LO register file and drives its 64-bit write data and write enable.
- Multiplies complete in one cycle with a registered result. Divides use a 32-iteration radix-2 restoring FSM and stall the pipeline while running.

Parameters:
- WIDTH, 32, operand width. HI/LO write data is 2*WIDTH bits. Only 32 is verified.
- DIV_ZERO_FAST, 1, if 1 a divide by zero skips iteration and goes straight to DONE. If 0 it runs the full iteration count.

Ports:
- clk  in  1  core clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- flush  in  1  exception or pipeline flush; cancels the current instruction and any running divide
- in_valid  in  1  op and operands are valid this cycle
- op  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- src_a  in  WIDTH  rs value (dividend / multiplicand / MT source)
- src_b  in  WIDTH  rt value (divisor / multiplier)
- hi_in  in  WIDTH  current HI value, read back from the HI/LO register
- lo_in  in  WIDTH  current LO value, read back from the HI/LO register
- stall  out  1  hold the execute stage
- hilo_wen  out  1  write enable for the HI/LO register
- hilo_wdata  out  2*WIDTH  {HI, LO} write data

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, counter=0, all datapath registers cleared.
  - hilo_wen=0, hilo_wdata=0.
  - stall=0, since stall is combinational from state and the state is IDLE.
- Sampling rule: in_valid/op are sampled only in IDLE. Inputs present in DIV or DONE are ignored, including the divide instruction still being held.
- IDLE, accepted op is MULT/MULTU/MTHI/MTLO, flush=0:
  - Next cycle: hilo_wen=1 for exactly one cycle. stall is never raised for these ops.
  - MULT: signed 32x32 to 64-bit product.
  - MULTU: unsigned 32x32 to 64-bit product.
  - MTHI: wdata = {src_a, lo_in}, with lo_in sampled at accept.
  - MTLO: wdata = {hi_in, src_a}, with hi_in sampled at accept.
  - Back-to-back accepts give back-to-back wen pulses.
- IDLE, accepted op is DIV/DIVU, flush=0:
  - stall=1 combinationally in the accept cycle.
  - Latch |src_a|, |src_b|, quotient sign and remainder sign. DIVU takes no absolute value.
  - Next state is DIV with counter=0.
- DIV state (stall=1):
  - One restoring step per cycle: shift the partial remainder left by 1, subtract the divisor, keep the result if non-negative, shift in the quotient bit.
  - counter increments each cycle. After counter=31 the next state is DONE.
  - Sign fixup happens on entry to DONE:
    - quotient is negated if the operand signs differ (DIV only);
    - remainder takes the dividend's sign (DIV only).
- DONE state (one cycle):
  - stall=0, hilo_wen=1, hilo_wdata={remainder, quotient}.
  - Next state is IDLE.
- Latency: divide accepted in cycle 0 writes in cycle 33, i.e. stall high for cycles 0..32.
- Divide by zero (src_b=0):
  - Result is {HI=src_a, LO=all-ones}.
  - With DIV_ZERO_FAST=1 it goes IDLE -> DONE, so stall is high only in the accept cycle and wen rises in cycle 1.
  - No exception is raised.
- Signed overflow case, DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (natural wrap). No trap.
- flush:
  - In IDLE: suppresses the accept and forces hilo_wen=0 next cycle. It also kills a registered MULT-class write pending from the previous cycle's accept, by clearing the pending wen.
  - In DIV or DONE: next state is IDLE, no wen, stall drops in the same cycle (combinational).
- Simultaneous flush and in_valid: flush wins.
- Reset asserted mid-divide: immediate abort, no write.
- hilo_wdata holds its last value when hilo_wen=0.

Decomposition:
- Shared package mdu_pkg:
  - op encodings MDU_NONE..MDU_MTLO (3-bit);
  - FSM state encodings S_IDLE, S_DIV, S_DONE;
  - DIV_ITERS=32.
- Sub-module div_iter: the combinational single restoring step. Inputs: partial remainder, dividend bit, divisor. Outputs: next remainder, quotient bit. It is instantiated once inside the FSM.
- The multiply uses inline operators. No sub-module is needed for it.

Test Plan:
- Reset, then MULT src_a=0xFFFFFFFE (-2), src_b=3 -> next cycle hilo_wen=1, hilo_wdata=0xFFFFFFFF_FFFFFFFA, stall never 1.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hilo_wdata=0xFFFFFFFE_00000001. Back-to-back MTHI src_a=0x12345678 with lo_in=0xA5A5A5A5 -> following cycle wdata=0x12345678_A5A5A5A5.
- DIV src_a=-7 (0xFFFFFFF9), src_b=2, op held high throughout -> stall=1 for cycles 0..32; cycle 33 hilo_wen=1, HI=0xFFFFFFFF (-1), LO=0xFFFFFFFD (-3); exactly one wen pulse; cycle 34 IDLE.
- DIVU 100/7 -> HI=2, LO=14. DIVU 5/0 (DIV_ZERO_FAST=1) -> stall only in cycle 0; cycle 1 wdata=0x00000005_FFFFFFFF.
- DIV started, flush=1 at cycle 10 -> stall=0 in cycle 10, no hilo_wen ever. Next MULT 2x3 is accepted in cycle 11 and writes 6 in cycle 12.
- reset driven to 0 at cycle 15 of a divide -> all outputs 0 immediately. After release, a new DIVU 9/3 completes normally with HI=0, LO=3.
